pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register for the five-stage MIPS core; one instance replaces each per-stage boundary register (F/D, D/E, E/M, M/W). It carries an opaque payload plus PC, exception code, branch-delay flag and a valid bit. It supports bubble insertion, exception flush to the handler vector, and a full freeze (hold) for multi-cycle units. Optional saturating performance counters record bubbles, flushes and hold cycles.

## Interface
- DATA_W, 96: payload width in bits (instr, imm, operands, ...).
- EXC_W, 5: exception code width; 0 = no exception.
- RESET_PC, 32'h0000_3000: pc_o value after reset.
- EXC_PC, 32'h0000_4180: pc_o value after flush.
- CNT_W, 32: perf counter width (used only with PIPE_PERF_EN).
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req  in  1  exception flush from CP0.
- hold  in  1  freeze this stage (downstream busy, e.g. mult/div).
- stall  in  1  insert bubble into this stage.
- pc_i  in  32  PC of incoming instruction.
- data_i  in  DATA_W  incoming payload.
- exc_i  in  EXC_W  incoming exception code.
- bd_i  in  1  incoming instruction is in a delay slot.
- valid_i  in  1  incoming slot holds a real instruction.
- pc_o, data_o, exc_o, bd_o, valid_o  out  32 / DATA_W / EXC_W / 1 / 1  registered copies.
- bubble_cnt_o, flush_cnt_o, hold_cnt_o  out  CNT_W each  perf counters (present only with PIPE_PERF_EN).

## Operation
- One action per rising edge, strict priority: reset > req > hold > stall > load.
- reset: pc_o=RESET_PC, data_o=0, exc_o=0, bd_o=0, valid_o=0.
- req: pc_o=EXC_PC, data_o=0, exc_o=0, bd_o=0, valid_o=0. Overrides hold and stall.
- hold: every output register keeps its value; inputs ignored.
- stall (bubble): pc_o=pc_i, bd_o=bd_i (preserved so CP0 sees correct EPC/BD for the bubble), data_o=0 (all-zero payload = nop), exc_o=0, valid_o=0.
- load: all outputs take their inputs unchanged, including valid_o=valid_i.
- Flushed or bubbled slots must never carry a nonzero exc_o.

## Timing
- Latency exactly 1 cycle input to output; no combinational path from any input to any output.
- Reset values: as in the reset row above; perf counters reset to 0.
- Simultaneous req+hold: flush taken. Simultaneous hold+stall: hold wins; the bubble is not inserted and the stall must be re-asserted by the hazard unit.
- reset asserted mid-hold or mid-stall: reset wins that edge; the next edge follows the normal priority order.
- Perf counters (with PIPE_PERF_EN), updated on the same edge as the action:
  - bubble_cnt_o +1 on an edge whose action is stall.
  - flush_cnt_o +1 on a req edge.
  - hold_cnt_o +1 on a hold edge.
  - All saturate at 2^CNT_W-1, never wrap; reset clears all three.

## Configuration
- PIPE_PERF_EN defined: three counters and their output ports exist.
- Not defined: the counter ports and logic are absent; the datapath behaviour is identical.

## Structure
- Shared package `pipe_pkg`: RESET_PC, EXC_PC, EXC_W, exception cause codes (Int, AdEL, AdES, RI, Ov), NOP payload constant.
- One sub-module, `pipe_sat_cnt` (CNT_W parameter; ports clk, reset, inc, cnt_o), instantiated three times under PIPE_PERF_EN.

## Test plan
- Reset: hold reset 2 cycles with pc_i=32'h1234 -> pc_o=32'h3000, data_o=0, valid_o=0, counters=0.
- Load: pc_i=32'h3004, data_i=96'hA5.., exc_i=5'd4, bd_i=1, valid_i=1 -> same values one cycle later.
- Stall: stall=1, pc_i=32'h3008, bd_i=1, exc_i=5'd10 -> pc_o=32'h3008, bd_o=1, data_o=0, exc_o=0, valid_o=0, bubble_cnt_o=1.
- Flush over hold: hold=1, req=1 -> pc_o=32'h4180, bd_o=0, valid_o=0, flush_cnt_o=1, hold_cnt_o unchanged.
- Hold over stall: load 32'h3010, then hold=1 and stall=1 for 3 cycles -> outputs frozen at 32'h3010 payload, hold_cnt_o=3, bubble_cnt_o unchanged.
- Saturation: with CNT_W=2, hold=1 for 5 cycles -> hold_cnt_o reaches 3 and stays at 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants, exception codes and action selection for pipeline stage registers
package pipe_pkg;
  localparam int EXC_W = 5;
  localparam int DATA_W = 96;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC = 32'h0000_4180;
  localparam logic [DATA_W-1:0] NOP_PAYLOAD = '0;
  // Zero means "no exception", so interrupts use code 1 instead of the raw MIPS ExcCode 0.
  typedef enum logic [EXC_W-1:0] {
    EXC_NONE = 5'd0,
    EXC_INT  = 5'd1,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;
  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_LOAD
  } act_e;
  function automatic act_e pick_act(input logic reset, input logic req, input logic hold, input logic stall);
    return reset ? ACT_RESET : req ? ACT_FLUSH : hold ? ACT_HOLD : stall ? ACT_BUBBLE : ACT_LOAD;
  endfunction
endpackage

// File: rtl/pipe_sat_cnt.sv
// pipe_sat_cnt: saturating event counter with synchronous clear
module pipe_sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt_o
);
  // count events, sticking at all-ones instead of wrapping
  always_ff @(posedge clk)
    if (reset) cnt_o <= '0;
    else if (inc && cnt_o != '1) cnt_o <= cnt_o + 1'b1;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline boundary register with flush, hold and bubble; PIPE_PERF_EN adds perf counters
module pipe_stage_reg #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int EXC_W = pipe_pkg::EXC_W,
  parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC,
  parameter logic [31:0] EXC_PC = pipe_pkg::EXC_PC
`ifdef PIPE_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              hold,
  input  logic              stall,
  input  logic [31:0]       pc_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [EXC_W-1:0]  exc_i,
  input  logic              bd_i,
  input  logic              valid_i,
  output logic [31:0]       pc_o,
  output logic [DATA_W-1:0] data_o,
  output logic [EXC_W-1:0]  exc_o,
  output logic              bd_o,
  output logic              valid_o
`ifdef PIPE_PERF_EN
  , output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] hold_cnt_o
`endif
);
  import pipe_pkg::*;
  act_e act;
  // resolve the single action for this edge by strict priority
  always_comb act = pick_act(reset, req, hold, stall);
  // hold keeps everything; bubbles keep pc/bd for EPC but carry a nop with no exception
  always_ff @(posedge clk)
    if (act != ACT_HOLD) begin
      pc_o    <= act == ACT_RESET ? RESET_PC : act == ACT_FLUSH ? EXC_PC : pc_i;
      data_o  <= act == ACT_LOAD ? data_i : DATA_W'(NOP_PAYLOAD);
      exc_o   <= act == ACT_LOAD ? exc_i : EXC_W'(EXC_NONE);
      bd_o    <= (act == ACT_LOAD || act == ACT_BUBBLE) && bd_i;
      valid_o <= act == ACT_LOAD && valid_i;
    end
`ifdef PIPE_PERF_EN
  pipe_sat_cnt #(.CNT_W(CNT_W)) u_bubble (.clk(clk), .reset(reset), .inc(act == ACT_BUBBLE), .cnt_o(bubble_cnt_o));
  pipe_sat_cnt #(.CNT_W(CNT_W)) u_flush (.clk(clk), .reset(reset), .inc(act == ACT_FLUSH), .cnt_o(flush_cnt_o));
  pipe_sat_cnt #(.CNT_W(CNT_W)) u_hold (.clk(clk), .reset(reset), .inc(act == ACT_HOLD), .cnt_o(hold_cnt_o));
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random checks of pipe_stage_reg against a priority-rule model (counters checked with PIPE_PERF_EN)
module tb_pipe_stage_reg;
  logic clk = 1'b0, reset = 1'b1, req = 1'b0, hold = 1'b0, stall = 1'b0;
  logic [31:0] pc_i = '0;
  logic [95:0] data_i = '0;
  logic [4:0] exc_i = '0;
  logic bd_i = 1'b0, valid_i = 1'b0;
  logic [31:0] pc_o;
  logic [95:0] data_o;
  logic [4:0] exc_o;
  logic bd_o, valid_o;
  logic [31:0] mpc;
  logic [95:0] mdata;
  logic [4:0] mexc;
  logic mbd, mvalid;
  longint mb, mf, mh, mh2;
  int n_chk = 0, n_fail = 0;
`ifdef PIPE_PERF_EN
  logic [31:0] bubble_cnt_o, flush_cnt_o, hold_cnt_o;
  logic [1:0] b2, f2, h2;
  logic [31:0] pc2;
  logic [95:0] data2;
  logic [4:0] exc2;
  logic bd2, valid2;
  pipe_stage_reg dut (.clk(clk), .reset(reset), .req(req), .hold(hold), .stall(stall), .pc_i(pc_i), .data_i(data_i), .exc_i(exc_i), .bd_i(bd_i), .valid_i(valid_i), .pc_o(pc_o), .data_o(data_o), .exc_o(exc_o), .bd_o(bd_o), .valid_o(valid_o), .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o), .hold_cnt_o(hold_cnt_o));
  pipe_stage_reg #(.CNT_W(2)) dut2 (.clk(clk), .reset(reset), .req(req), .hold(hold), .stall(stall), .pc_i(pc_i), .data_i(data_i), .exc_i(exc_i), .bd_i(bd_i), .valid_i(valid_i), .pc_o(pc2), .data_o(data2), .exc_o(exc2), .bd_o(bd2), .valid_o(valid2), .bubble_cnt_o(b2), .flush_cnt_o(f2), .hold_cnt_o(h2));
`else
  pipe_stage_reg dut (.clk(clk), .reset(reset), .req(req), .hold(hold), .stall(stall), .pc_i(pc_i), .data_i(data_i), .exc_i(exc_i), .bd_i(bd_i), .valid_i(valid_i), .pc_o(pc_o), .data_o(data_o), .exc_o(exc_o), .bd_o(bd_o), .valid_o(valid_o));
`endif
  always #5 clk = ~clk;
  function automatic longint sat(input longint v, input longint mx);
    return v >= mx ? mx : v + 1;
  endfunction
  // advance the reference model by one edge from the current inputs, then clock the DUT
  task automatic step();
    if (reset) begin
      mpc = 32'h0000_3000; mdata = '0; mexc = '0; mbd = 0; mvalid = 0;
      mb = 0; mf = 0; mh = 0; mh2 = 0;
    end else if (req) begin
      mpc = 32'h0000_4180; mdata = '0; mexc = '0; mbd = 0; mvalid = 0;
      mf = sat(mf, 64'hFFFF_FFFF);
    end else if (hold) begin
      mh = sat(mh, 64'hFFFF_FFFF); mh2 = sat(mh2, 3);
    end else if (stall) begin
      mpc = pc_i; mdata = '0; mexc = '0; mbd = bd_i; mvalid = 0;
      mb = sat(mb, 64'hFFFF_FFFF);
    end else begin
      mpc = pc_i; mdata = data_i; mexc = exc_i; mbd = bd_i; mvalid = valid_i;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag);
    n_chk++; assert (pc_o === mpc) else begin n_fail++; $error("FAIL %s pc_o got %h exp %h", tag, pc_o, mpc); end
    n_chk++; assert (data_o === mdata) else begin n_fail++; $error("FAIL %s data_o got %h exp %h", tag, data_o, mdata); end
    n_chk++; assert (exc_o === mexc) else begin n_fail++; $error("FAIL %s exc_o got %h exp %h", tag, exc_o, mexc); end
    n_chk++; assert (bd_o === mbd) else begin n_fail++; $error("FAIL %s bd_o got %b exp %b", tag, bd_o, mbd); end
    n_chk++; assert (valid_o === mvalid) else begin n_fail++; $error("FAIL %s valid_o got %b exp %b", tag, valid_o, mvalid); end
`ifdef PIPE_PERF_EN
    n_chk++; assert (bubble_cnt_o === 32'(mb)) else begin n_fail++; $error("FAIL %s bubble_cnt got %0d exp %0d", tag, bubble_cnt_o, mb); end
    n_chk++; assert (flush_cnt_o === 32'(mf)) else begin n_fail++; $error("FAIL %s flush_cnt got %0d exp %0d", tag, flush_cnt_o, mf); end
    n_chk++; assert (hold_cnt_o === 32'(mh)) else begin n_fail++; $error("FAIL %s hold_cnt got %0d exp %0d", tag, hold_cnt_o, mh); end
    n_chk++; assert (h2 === 2'(mh2)) else begin n_fail++; $error("FAIL %s hold_cnt_w2 got %0d exp %0d", tag, h2, mh2); end
    n_chk++; assert (pc2 === mpc && data2 === mdata && valid2 === mvalid) else begin n_fail++; $error("FAIL %s w2_datapath got %h exp %h", tag, pc2, mpc); end
`endif
  endtask
  initial begin
    pc_i = 32'h1234;
    step(); step(); check("reset");
    reset = 0; pc_i = 32'h3004; data_i = {12{8'hA5}}; exc_i = 5'd4; bd_i = 1; valid_i = 1;
    step(); check("load");
    stall = 1; pc_i = 32'h3008; exc_i = 5'd10; bd_i = 1;
    step(); check("stall");
    stall = 0; hold = 1; req = 1;
    step(); check("flush_over_hold");
    hold = 0; req = 0; pc_i = 32'h3010; data_i = {3{32'hDEAD_BEEF}}; exc_i = 5'd12; bd_i = 0; valid_i = 1;
    step(); check("load_3010");
    hold = 1; stall = 1; pc_i = 32'h3014; data_i = '1; exc_i = 5'd5; bd_i = 1; valid_i = 0;
    for (int i = 0; i < 3; i++) begin step(); check("hold_over_stall"); end
    stall = 0;
    for (int i = 0; i < 2; i++) begin step(); check("hold_saturate"); end
    hold = 0; stall = 1; reset = 1;
    step(); check("reset_mid_stall");
    reset = 0; stall = 0;
    for (int i = 0; i < 400; i++) begin
      reset = $urandom_range(0, 99) < 3;
      req = $urandom_range(0, 99) < 10;
      hold = $urandom_range(0, 99) < 25;
      stall = $urandom_range(0, 99) < 25;
      pc_i = $urandom; data_i = {$urandom, $urandom, $urandom};
      exc_i = 5'($urandom); bd_i = 1'($urandom); valid_i = 1'($urandom);
      step(); check("random");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
